// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_ctrl
// Description : Dot-product sequencer for a single MAC unit. It clears the
//               accumulator, streams len operand pairs through a valid/ready
//               handshake, then presents the captured sum on a valid/ready port.
//               The optional macro MAC_SEQ_STALL_CNT_EN adds a saturating
//               stall_cycles counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic                    abort,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic [DATA_WIDTH-1:0]   mac_ain,
    output logic [DATA_WIDTH-1:0]   mac_bin,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
`ifdef MAC_SEQ_STALL_CNT_EN
    output logic [15:0]             stall_cycles,
`endif
    output logic [3*DATA_WIDTH-1:0] result
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_clear  = 3'd1;
    localparam logic [2:0] c_accum  = 3'd2;
    localparam logic [2:0] c_drain  = 3'd3;
    localparam logic [2:0] c_result = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_cnt;
    logic [3*DATA_WIDTH-1:0] r_result;
    logic                    w_in_op;
    logic                    w_abort;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_cmd;

    assign w_in_op  = (r_state != c_idle);
    assign w_abort  = w_in_op && abort;
    assign w_cmd    = (r_state == c_idle) && start && !abort;
    assign op_ready = (r_state == c_accum) && !abort;
    assign w_accept = op_valid && op_ready;
    assign w_last   = (r_cnt == r_len - LEN_WIDTH'(1));

    assign mac_en    = w_accept;
    assign mac_clr   = (r_state == c_clear) || w_abort;
    assign mac_ain   = op_a;
    assign mac_bin   = op_b;
    assign busy      = w_in_op;
    assign res_valid = (r_state == c_result);
    assign result    = r_result;

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = c_idle;
        end else begin
            case (r_state)
                c_idle:   if (w_cmd) w_state_nxt = c_clear;
                c_clear:  w_state_nxt = (r_len == '0) ? c_drain : c_accum;
                c_accum:  if (w_accept && w_last) w_state_nxt = c_drain;
                c_drain:  w_state_nxt = c_result;
                c_result: if (res_ready) w_state_nxt = c_idle;
                default:  w_state_nxt = c_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_len    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd) begin
                r_len <= len;
            end
            // Counter only lives while in ACCUM, so it is zero on every entry.
            if (w_state_nxt != c_accum) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + LEN_WIDTH'(1);
            end
            if ((r_state == c_drain) && !abort) begin
                r_result <= mac_cout;
            end
        end
    end

`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_cmd) begin
            r_stall <= '0;
        end else if ((r_state == c_accum) && !op_valid && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_seq_ctrl
// Description : Self-checking bench for mac_seq_ctrl with an attached MAC model;
//               expected sums, beat timing and latency come from a dot-product
//               reference computed over the operand pairs the bench presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        mac_en;
    logic        mac_clr;
    logic [7:0]  mac_ain;
    logic [7:0]  mac_bin;
    logic [23:0] mac_cout = '0;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] result;
`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [7:0] pa [0:255];
    logic [7:0] pb [0:255];

    always #5 clk = ~clk;

    mac_seq_ctrl #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_ain   (mac_ain),
        .mac_bin   (mac_bin),
        .mac_cout  (mac_cout),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
`ifdef MAC_SEQ_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .result    (result)
    );

    // Attached MAC: registered accumulator, clear has priority over enable.
    always @(posedge clk) begin
        if (mac_clr)     mac_cout <= '0;
        else if (mac_en) mac_cout <= mac_cout + 24'(mac_ain) * 24'(mac_bin);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after the falling edge of an IDLE cycle; that cycle is cycle 0.
    task automatic run_op(input int n, input int stall_pct, input int gap_at, input int gap_len,
                          input int hold, input bit poke, input int exp_rv);
        logic [23:0] exp_sum;
        int  sent, stalls, cyc, rv_cyc, gap_used;
        bit  v, in_acc, exp_en, done;
        exp_sum = '0;
        for (int i = 0; i < n; i++) exp_sum += 24'(pa[i]) * 24'(pb[i]);
        sent = 0; stalls = 0; cyc = 0; gap_used = 0; done = 0;
        rv_cyc = (n == 0) ? 3 : -1;
        start = 1'b1; len = 8'(n); abort = 1'b0; res_ready = 1'b0;
        op_valid = 1'(($urandom_range(1)));
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        while (!done && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            in_acc = (cyc >= 2) && (sent < n);
            if (in_acc) begin
                if (sent == gap_at && gap_used < gap_len) begin
                    v = 1'b0;
                    gap_used++;
                end else begin
                    v = (int'($urandom_range(99)) >= stall_pct);
                end
            end else begin
                v = 1'(($urandom_range(1)));
            end
            op_valid = v;
            if (in_acc && v) begin
                op_a = pa[sent]; op_b = pb[sent];
            end else begin
                op_a = 8'($urandom); op_b = 8'($urandom);
            end
            exp_en = in_acc && v;
            @(negedge clk);
            chk("mac_en", 32'(mac_en), 32'(exp_en));
            chk("mac_clr", 32'(mac_clr), 32'(cyc == 1));
            chk("res_valid", 32'(res_valid), 32'(rv_cyc > 0 && cyc >= rv_cyc));
            chk("busy", 32'(busy), 32'd1);
            if (exp_en) begin
                chk("mac_ain", 32'(mac_ain), 32'(pa[sent]));
                chk("mac_bin", 32'(mac_bin), 32'(pb[sent]));
                sent++;
                if (sent == n) rv_cyc = cyc + 2;
            end else if (in_acc) begin
                stalls++;
            end
            if (rv_cyc > 0 && cyc == rv_cyc) done = 1'b1;
        end
        chk("rv_reached", 32'(done), 32'd1);
        if (exp_rv >= 0) chk("rv_cycle", 32'(cyc), 32'(exp_rv));
        chk("result", 32'(result), 32'(exp_sum));
`ifdef MAC_SEQ_STALL_CNT_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(stalls));
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            start = poke; len = 8'd5; op_valid = 1'(($urandom_range(1)));
            @(negedge clk);
            chk("hold_rv", 32'(res_valid), 32'd1);
            chk("hold_result", 32'(result), 32'(exp_sum));
            chk("hold_en", 32'(mac_en), 32'd0);
        end
        @(posedge clk); #1;
        start = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        chk("hs_rv", 32'(res_valid), 32'd1);
        @(posedge clk); #1;
        res_ready = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_rv", 32'(res_valid), 32'd0);
        chk("post_result", 32'(result), 32'(exp_sum));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(op_ready), 32'd0);
        chk("rst_en", 32'(mac_en), 32'd0);
        chk("rst_clr", 32'(mac_clr), 32'd0);
        chk("rst_rv", 32'(res_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst = 1'b0;

        // Continuous operands, 1*2+3*4+5*6+7*8 = 100.
        for (int i = 0; i < 4; i++) begin pa[i] = 8'(2*i+1); pb[i] = 8'(2*i+2); end
        run_op(4, 0, -1, 0, 0, 1'b0, 7);

        // Two-cycle gap after the first beat.
        for (int i = 0; i < 3; i++) begin pa[i] = 8'd255; pb[i] = 8'd255; end
        run_op(3, 0, 1, 2, 0, 1'b0, 8);

        // Zero length.
        run_op(0, 0, -1, 0, 0, 1'b0, 3);

        // Result backpressure with start pokes during RESULT.
        pa[0] = 8'd9; pb[0] = 8'd7; pa[1] = 8'd200; pb[1] = 8'd100;
        run_op(2, 0, -1, 0, 5, 1'b1, 5);

        // start together with abort while idle is ignored.
        start = 1'b1; abort = 1'b1; len = 8'd3;
        #1;
        chk("idle_abort_clr", 32'(mac_clr), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 32'd0);

        // Abort after three accepted beats of an 8-beat run.
        start = 1'b1; len = 8'd8; op_valid = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; op_valid = 1'b1; op_a = 8'd1; op_b = 8'd1;
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(negedge clk);
        chk("abort_clr", 32'(mac_clr), 32'd1);
        chk("abort_en", 32'(mac_en), 32'd0);
        chk("abort_ready", 32'(op_ready), 32'd0);
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rv", 32'(res_valid), 32'd0);
        @(posedge clk); #1; op_valid = 1'b0;
        @(negedge clk);
        chk("abort_rv2", 32'(res_valid), 32'd0);
        pa[0] = 8'd2; pb[0] = 8'd3; pa[1] = 8'd4; pb[1] = 8'd5;
        run_op(2, 0, -1, 0, 0, 1'b0, 5);

        // Reset during ACCUM.
        start = 1'b1; len = 8'd6;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; op_valid = 1'b1; op_a = 8'd3; op_b = 8'd3;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(op_ready), 32'd0);
        chk("mrst_en", 32'(mac_en), 32'd0);
        chk("mrst_clr", 32'(mac_clr), 32'd0);
        chk("mrst_rv", 32'(res_valid), 32'd0);
        chk("mrst_result", 32'(result), 32'd0);
        op_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
        run_op(5, 0, -1, 0, 0, 1'b0, 8);

        // Randomized runs, including the maximum length.
        for (int r = 0; r < 10; r++) begin
            int n;
            n = (r == 9) ? 255 : int'($urandom_range(0, 20));
            for (int i = 0; i < 256; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
            run_op(n, (r == 9) ? 10 : 30, -1, 0, int'($urandom_range(0, 3)), 1'(($urandom_range(1))), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
